forward_nn: RTL and testbench
=============================

// Module: forward_nn
// PURPOSE
//  Sequential forward-propagation engine for the N_IN-N_HL_P-N_OUT sigmoid network.
//  It is the forward counterpart of the delta stage:
//   - produces the hidden activations and output activations that the delta stage consumes;
//   - uses the same packed weight layouts as the delta stage.
//  A single shared multiply-accumulate (MAC) is time-multiplexed over all neurons, controlled by an FSM.
//  A start/done handshake lets the training controller sequence forward pass -> delta -> update.
// PARAMETERS
//  N_IN    2   input-layer width
//  N_HL_P  3   hidden perceptrons
//  N_OUT   2   output perceptrons
//  WIDTH   32  signed fixed-point word width
//  FRAC    24  fractional bits (default Q8.24)
// PORTS
//  clk       in   1                  clock, rising edge
//  rst_n     in   1                  asynchronous reset, active-low
//  i_start   in   1                  start request; accepted only while o_busy=0
//  i_x       in   N_IN*WIDTH         inputs; element i at [(i+1)*WIDTH-1 : i*WIDTH]
//  i_hd_w    in   N_HL_P*N_IN*WIDTH  hidden weights; element h*N_IN+i = input i -> hidden h
//  i_hd_b    in   N_HL_P*WIDTH       hidden biases
//  i_out_w   in   N_OUT*N_HL_P*WIDTH output weights; element o*N_HL_P+h = hidden h -> output o
//  i_out_b   in   N_OUT*WIDTH        output biases
//  o_busy    out  1                  high from start acceptance until the o_done cycle inclusive
//  o_done    out  1                  one-cycle pulse; results valid from this cycle onward
//  o_hd_a    out  N_HL_P*WIDTH       hidden activations (packed like i_hd_b)
//  o_out_a   out  N_OUT*WIDTH        output activations (packed like i_out_b)
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0):
//   - FSM goes to IDLE; o_busy=0, o_done=0, o_hd_a=0, o_out_a=0; accumulator and counters cleared.
//   - Reset mid-pass aborts the pass; no partial results are ever exposed.
//  Start:
//   - i_start sampled high in IDLE captures all of i_x, i_hd_w, i_hd_b, i_out_w, i_out_b into internal registers.
//   - FSM then enters HMAC. Input changes after capture have no effect on the pass.
//   - i_start while busy is ignored; it is not queued.
//  FSM sequence: IDLE -> HMAC -> HACT -> (next hidden | OMAC) -> OACT -> (next output | DONE) -> IDLE.
//   - Neuron start: acc <= bias.
//   - Each MAC cycle: acc += product, one operand pair per cycle.
//   - HACT/OACT (one cycle): writes sigmoid(acc) into the shadow activation register.
//   - OMAC reads the hidden shadow activations computed in this pass.
//  Latency:
//   - o_done is high exactly N_HL_P*(N_IN+1) + N_OUT*(N_HL_P+1) + 1 cycles after the accepting edge.
//   - With default parameters this is 18 cycles.
//  Result update:
//   - o_hd_a and o_out_a update together, in the DONE cycle; they are otherwise held stable.
//   - o_done and o_busy fall on the next edge, returning to IDLE.
//   - A new start is accepted on the first IDLE cycle.
//  Arithmetic:
//   - Product is the full 2*WIDTH signed result, arithmetic-shifted right by FRAC (truncation toward -inf).
//   - Accumulator is WIDTH+4 bits signed; no intermediate saturation.
//  Sigmoid (PLAN, shifts/adds only), with a=|acc|:
//   - a >= 5.0           -> 1.0
//   - 2.375 <= a < 5.0   -> a/32 + 0.84375
//   - 1.0 <= a < 2.375   -> a/8 + 0.625
//   - a < 1.0            -> a/4 + 0.5
//   - acc < 0            -> result = 1.0 - f(a)
//   - Result is WIDTH bits in [0, 1.0].
// TESTING
//  1. All weights and biases 0, i_x arbitrary, pulse i_start -> o_done at cycle 18;
//     o_hd_a all 0x00800000; o_out_a all 0x00800000.
//  2. i_x = {1.0, 1.0}, all i_hd_w = 0x00800000 (0.5), i_hd_b = 0 -> every o_hd_a = 0x00C00000 (0.75).
//     Same with i_x = -1.0 -> 0x00400000 (0.25).
//  3. i_hd_w = 0, i_hd_b = {6.0, 2.375, -6.0} -> o_hd_a = {0x01000000, 0x00EB0000, 0x00000000}.
//     This exercises saturation, the 2.375 breakpoint and the negative branch.
//  4. i_hd_b = 6.0 (hidden = 1.0), all i_out_w = 1.0, i_out_b = -3.0 -> o_out_a all 0x00800000.
//  5. Second i_start at cycles 1 and 17 of a pass -> both ignored, exactly one o_done;
//     inputs changed mid-pass -> results match the captured inputs.
//  6. rst_n low at cycle 10 of a pass -> all outputs 0 immediately;
//     a fresh start after release completes correctly in 18 cycles.

Source files
------------

// File: rtl/forward_nn.sv
`default_nettype none
// ============================================================================
// Module  : forward_nn
// Brief   : Sequential forward pass of an N_IN-N_HL_P-N_OUT sigmoid network
//           built around one shared, time-multiplexed MAC.
// Revision: 1.0
// ============================================================================
module forward_nn #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [N_IN*WIDTH-1:0]           i_x,
    input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_hd_w,
    input  logic [N_HL_P*WIDTH-1:0]         i_hd_b,
    input  logic [N_OUT*N_HL_P*WIDTH-1:0]   i_out_w,
    input  logic [N_OUT*WIDTH-1:0]          i_out_b,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [N_HL_P*WIDTH-1:0]         o_hd_a,
    output logic [N_OUT*WIDTH-1:0]          o_out_a
);

    localparam int AW = WIDTH + 4;
    localparam int PW = 2 * WIDTH;

    localparam logic [AW-1:0] c_one  = AW'(64'd1  << FRAC);
    localparam logic [AW-1:0] c_half = AW'(64'd1  << (FRAC - 1));
    localparam logic [AW-1:0] c_five = AW'(64'd5  << FRAC);
    localparam logic [AW-1:0] c_brk  = AW'(64'd19 << (FRAC - 3));
    localparam logic [AW-1:0] c_k1   = AW'(64'd5  << (FRAC - 3));
    localparam logic [AW-1:0] c_k2   = AW'(64'd27 << (FRAC - 5));

    localparam logic [7:0] c_in_last  = 8'(N_IN - 1);
    localparam logic [7:0] c_hl_last  = 8'(N_HL_P - 1);
    localparam logic [7:0] c_out_last = 8'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HMAC = 3'd1,
        S_HACT = 3'd2,
        S_OMAC = 3'd3,
        S_OACT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                         r_state;
    logic [7:0]                     r_n;
    logic [7:0]                     r_k;
    logic signed [AW-1:0]           r_acc;
    logic [N_IN*WIDTH-1:0]          r_x;
    logic [N_HL_P*N_IN*WIDTH-1:0]   r_hw;
    logic [N_HL_P*WIDTH-1:0]        r_hb;
    logic [N_OUT*N_HL_P*WIDTH-1:0]  r_ow;
    logic [N_OUT*WIDTH-1:0]         r_ob;
    logic [N_HL_P*WIDTH-1:0]        r_hd_sh;
    logic [N_OUT*WIDTH-1:0]         r_out_sh;

    logic signed [WIDTH-1:0]        w_opa;
    logic signed [WIDTH-1:0]        w_opb;
    logic signed [PW-1:0]           w_prod;
    logic signed [AW-1:0]           w_term;
    logic [WIDTH-1:0]               w_sig;
    logic [N_OUT*WIDTH-1:0]         w_out_next;

    function automatic logic signed [AW-1:0] ext(input logic [WIDTH-1:0] v);
        return {{(AW - WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Piecewise-linear sigmoid; negative inputs use the 1 - f(|x|) symmetry.
    function automatic logic [WIDTH-1:0] sigmoid(input logic signed [AW-1:0] acc);
        logic [AW-1:0] a;
        logic [AW-1:0] f;
        a = acc[AW-1] ? AW'(-acc) : AW'(acc);
        if (a >= c_five)
            f = c_one;
        else if (a >= c_brk)
            f = (a >> 5) + c_k2;
        else if (a >= c_one)
            f = (a >> 3) + c_k1;
        else
            f = (a >> 2) + c_half;
        if (acc[AW-1])
            f = c_one - f;
        return WIDTH'(f);
    endfunction

    always_comb begin
        w_opa = '0;
        w_opb = '0;
        if (r_state == S_OMAC) begin
            w_opa = r_hd_sh[32'(r_k)*WIDTH +: WIDTH];
            w_opb = r_ow[(32'(r_n)*N_HL_P + 32'(r_k))*WIDTH +: WIDTH];
        end else begin
            w_opa = r_x[32'(r_k)*WIDTH +: WIDTH];
            w_opb = r_hw[(32'(r_n)*N_IN + 32'(r_k))*WIDTH +: WIDTH];
        end
    end

    assign w_prod = w_opa * w_opb;
    assign w_term = AW'(w_prod >>> FRAC);
    assign w_sig  = sigmoid(r_acc);

    always_comb begin
        w_out_next = r_out_sh;
        w_out_next[32'(r_n)*WIDTH +: WIDTH] = w_sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_hw     <= '0;
            r_hb     <= '0;
            r_ow     <= '0;
            r_ob     <= '0;
            r_hd_sh  <= '0;
            r_out_sh <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_hd_a   <= '0;
            o_out_a  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x     <= i_x;
                        r_hw    <= i_hd_w;
                        r_hb    <= i_hd_b;
                        r_ow    <= i_out_w;
                        r_ob    <= i_out_b;
                        r_acc   <= ext(i_hd_b[WIDTH-1:0]);
                        r_n     <= '0;
                        r_k     <= '0;
                        o_busy  <= 1'b1;
                        r_state <= S_HMAC;
                    end
                end
                S_HMAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == c_in_last) begin
                        r_k     <= '0;
                        r_state <= S_HACT;
                    end else begin
                        r_k <= r_k + 8'd1;
                    end
                end
                // Activation cycle also preloads the next neuron's bias.
                S_HACT: begin
                    r_hd_sh[32'(r_n)*WIDTH +: WIDTH] <= w_sig;
                    if (r_n == c_hl_last) begin
                        r_n     <= '0;
                        r_acc   <= ext(r_ob[WIDTH-1:0]);
                        r_state <= S_OMAC;
                    end else begin
                        r_n     <= r_n + 8'd1;
                        r_acc   <= ext(r_hb[(32'(r_n) + 1)*WIDTH +: WIDTH]);
                        r_state <= S_HMAC;
                    end
                end
                S_OMAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == c_hl_last) begin
                        r_k     <= '0;
                        r_state <= S_OACT;
                    end else begin
                        r_k <= r_k + 8'd1;
                    end
                end
                S_OACT: begin
                    r_out_sh <= w_out_next;
                    if (r_n == c_out_last) begin
                        o_hd_a  <= r_hd_sh;
                        o_out_a <= w_out_next;
                        o_done  <= 1'b1;
                        r_n     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_n     <= r_n + 8'd1;
                        r_acc   <= ext(r_ob[(32'(r_n) + 1)*WIDTH +: WIDTH]);
                        r_state <= S_OMAC;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_nn.sv
`default_nettype none
// ============================================================================
// Module  : tb_forward_nn
// Brief   : Directed-vector bench for forward_nn (Q8.24, 2-3-2 network).
// Revision: 1.0
// ============================================================================
module tb_forward_nn;

    localparam int WIDTH = 32;

    typedef struct {
        string          name;
        logic [63:0]    x;
        logic [191:0]   hw;
        logic [95:0]    hb;
        logic [191:0]   ow;
        logic [63:0]    ob;
        logic [95:0]    exp_hd;
        logic [63:0]    exp_out;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [63:0]    i_x = '0;
    logic [191:0]   i_hd_w = '0;
    logic [95:0]    i_hd_b = '0;
    logic [191:0]   i_out_w = '0;
    logic [63:0]    i_out_b = '0;
    logic           o_busy;
    logic           o_done;
    logic [95:0]    o_hd_a;
    logic [63:0]    o_out_a;

    int             n_checks = 0;
    int             n_fail = 0;
    logic [95:0]    prev_hd = '0;
    logic [63:0]    prev_out = '0;
    vec_t           vecs[7];

    forward_nn #(.N_IN(2), .N_HL_P(3), .N_OUT(2), .WIDTH(WIDTH), .FRAC(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_x     (i_x),
        .i_hd_w  (i_hd_w),
        .i_hd_b  (i_hd_b),
        .i_out_w (i_out_w),
        .i_out_b (i_out_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hd_a  (o_hd_a),
        .o_out_a (o_out_a)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_x     = v.x;
        i_hd_w  = v.hw;
        i_hd_b  = v.hb;
        i_out_w = v.ow;
        i_out_b = v.ob;
    endtask

    // Starts a pass in the next cycle; lat is the cycle (1 = right after the
    // accepting edge) in which o_done was first seen, or 0 on timeout.
    task automatic run_pass(input vec_t v, output int lat);
        @(negedge clk);
        check({v.name, " idle"}, {o_busy, o_done}, 2'b00);
        drive(v);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({v.name, " busy"}, o_busy, 1'b1);
        lat = 1;
        while (!o_done && lat < 40) begin
            if (lat == 17)
                check({v.name, " hold"}, {o_hd_a, o_out_a}, {prev_hd, prev_out});
            @(negedge clk);
            lat++;
        end
        if (!o_done) lat = 0;
        check({v.name, " latency"}, lat, 18);
        check({v.name, " hd_a"}, o_hd_a, v.exp_hd);
        check({v.name, " out_a"}, o_out_a, v.exp_out);
        prev_hd  = v.exp_hd;
        prev_out = v.exp_out;
    endtask

    initial begin
        int lat;
        int dones;

        vecs[0] = '{"zero", 64'h0, 192'h0, 96'h0, 192'h0, 64'h0,
                    {3{32'h00800000}}, {2{32'h00800000}}};
        vecs[1] = '{"pos", {2{32'h01000000}}, {6{32'h00800000}}, 96'h0, 192'h0, 64'h0,
                    {3{32'h00C00000}}, {2{32'h00800000}}};
        vecs[2] = '{"neg", {2{32'hFF000000}}, {6{32'h00800000}}, 96'h0, 192'h0, 64'h0,
                    {3{32'h00400000}}, {2{32'h00800000}}};
        vecs[3] = '{"brk", 64'h0, 192'h0, {32'hFA000000, 32'h02600000, 32'h06000000},
                    192'h0, 64'h0,
                    {32'h00000000, 32'h00EB0000, 32'h01000000}, {2{32'h00800000}}};
        vecs[4] = '{"outl", 64'h0, 192'h0, {3{32'h06000000}}, {6{32'h01000000}},
                    {2{32'hFD000000}}, {3{32'h01000000}}, {2{32'h00800000}}};
        vecs[5] = '{"mix", {32'h02000000, 32'h00800000},
                    {32'h0, 32'hFF000000, 32'h01000000, 32'h0, 32'h0, 32'h01000000},
                    {32'h00400000, 32'h0, 32'h0},
                    {32'hFE000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h01000000}, 64'h0,
                    {32'h00700000, 32'h00E00000, 32'h00A00000},
                    {32'h00480000, 32'h00A80000}};
        vecs[6] = '{"five", 64'h0, 192'h0, {32'h01000000, 32'h04FFFFFF, 32'h05000000},
                    192'h0, 64'h0,
                    {32'h00C00000, 32'h00FFFFFF, 32'h01000000}, {2{32'h00800000}}};

        #12;
        check("reset state", {o_busy, o_done, o_hd_a, o_out_a}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_pass(vecs[i], lat);

        // Start re-requested mid-pass and inputs changed after capture.
        @(negedge clk);
        drive(vecs[5]);
        i_start = 1'b1;
        dones = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            i_start = (c == 1 || c == 17);
            if (c == 2) drive(vecs[1]);
            if (o_done) begin
                dones++;
                check("ignored-start done cycle", c, 18);
                check("captured hd_a", o_hd_a, vecs[5].exp_hd);
                check("captured out_a", o_out_a, vecs[5].exp_out);
            end
        end
        i_start = 1'b0;
        check("single done", dones, 1);
        check("idle after ignored start", o_busy, 1'b0);

        // Asynchronous reset mid-pass.
        @(negedge clk);
        drive(vecs[3]);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset mid-pass", {o_busy, o_done, o_hd_a, o_out_a}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_hd  = '0;
        prev_out = '0;
        run_pass(vecs[4], lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
